// File: rtl/button_event_queue.sv
// Merges per-button down/up/short/long pulses into one prioritised event FIFO.
// Optional per-entry millisecond timestamps are enabled with `define BTN_EVQ_TIMESTAMP_EN.
module button_event_queue #(
  parameter int CLK_HZ     = 27000000,
  parameter int NUM_BTN    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_BTN-1:0]            btn_down,
  input  logic [NUM_BTN-1:0]            btn_up,
  input  logic [NUM_BTN-1:0]            btn_shrt,
  input  logic [NUM_BTN-1:0]            btn_long,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_data,
  output logic [15:0]                   ev_ts,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int NP = 4 * NUM_BTN;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (CLK_HZ < 1000 || NUM_BTN < 1 || NUM_BTN > 64 || FIFO_DEPTH < 2 ||
      FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("button_event_queue: parameter out of range");
  end

  logic [NP-1:0] in_flat;
  logic [NP-1:0] in_q;
  logic [NP-1:0] rise;
  logic [NP-1:0] pending;
  logic [NP-1:0] push_mask;
  logic [7:0]    sel_k;
  logic          sel_vld;
  logic          pop;
  logic          can_accept;
  logic          push;
  logic          merge;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    data_mem [FIFO_DEPTH];

  // Flat index k = 4*button + type, so ascending k is the delivery priority.
  always_comb begin
    in_flat = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      in_flat[4*i+0] = btn_down[i];
      in_flat[4*i+1] = btn_up[i];
      in_flat[4*i+2] = btn_shrt[i];
      in_flat[4*i+3] = btn_long[i];
    end
  end

  assign rise = in_flat & ~in_q;

  always_comb begin
    sel_k   = '0;
    sel_vld = 1'b0;
    for (int k = NP - 1; k >= 0; k--) begin
      if (pending[k]) begin
        sel_k   = 8'(k);
        sel_vld = 1'b1;
      end
    end
  end

  assign ev_valid   = (ev_count != '0);
  assign pop        = ev_valid & ev_ready;
  assign can_accept = (ev_count < CW'(FIFO_DEPTH)) | pop;
  assign push       = sel_vld & can_accept;
  assign push_mask  = push ? ({{(NP-1){1'b0}}, 1'b1} << sel_k) : '0;
  // A rise on the bit being pushed this cycle is a fresh event, not a merge.
  assign merge      = |(rise & pending & ~push_mask);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_q     <= '0;
      pending  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ev_count <= '0;
      ovf      <= 1'b0;
    end else begin
      in_q    <= in_flat;
      pending <= (pending & ~push_mask) | rise;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   ev_count <= ev_count + CW'(1);
        2'b01:   ev_count <= ev_count - CW'(1);
        default: ev_count <= ev_count;
      endcase
      if (merge)        ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // When full with a simultaneous pop, wr_ptr equals rd_ptr; the old head is read before the edge.
  always_ff @(posedge clk) begin
    if (push) data_mem[wr_ptr] <= {sel_k[1:0], sel_k[7:2]};
  end

  assign ev_data = ev_valid ? data_mem[rd_ptr] : 8'd0;

`ifdef BTN_EVQ_TIMESTAMP_EN
  localparam int MS_DIV = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;

  logic [31:0] pre_cnt;
  logic [15:0] ms_cnt;
  logic [15:0] ts_mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pre_cnt <= 32'(MS_DIV - 1);
      ms_cnt  <= '0;
    end else if (pre_cnt == '0) begin
      pre_cnt <= 32'(MS_DIV - 1);
      ms_cnt  <= ms_cnt + 16'd1;
    end else begin
      pre_cnt <= pre_cnt - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ts_mem[wr_ptr] <= ms_cnt;
  end

  assign ev_ts = ev_valid ? ts_mem[rd_ptr] : 16'd0;
`else
  assign ev_ts = 16'd0;
`endif

endmodule

// File: tb/tb_button_event_queue.sv
// Scoreboard bench for button_event_queue: expected codes are queued at stimulus
// time and compared against the FIFO head as it is drained.
module tb_button_event_queue;

  localparam int NUM_BTN    = 4;
  localparam int FIFO_DEPTH = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] btn_down, btn_up, btn_shrt, btn_long;
  logic       ev_valid, ev_ready, ovf, ovf_clr;
  logic [7:0] ev_data;
  logic [15:0] ev_ts;
  logic [3:0] ev_count;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  button_event_queue #(.CLK_HZ(1000), .NUM_BTN(NUM_BTN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .btn_down(btn_down), .btn_up(btn_up), .btn_shrt(btn_shrt), .btn_long(btn_long),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data), .ev_ts(ev_ts),
    .ev_count(ev_count), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    btn_down = '0; btn_up = '0; btn_shrt = '0; btn_long = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0; clear_inputs();
    repeat (3) @(negedge clk);
    checks += 5;
    if (ev_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ev_valid); end
    if (ev_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", ev_data); end
    if (ev_ts !== 16'h0)   begin failures++; $display("FAIL reset_ts got=%h exp=0000", ev_ts); end
    if (ev_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", ev_count); end
    if (ovf !== 1'b0)      begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] e;
    int c;
    btn_shrt[2] = 1'b1;
    @(negedge clk);
    checks++;
    if (ev_valid !== 1'b0) begin failures++; $display("FAIL single_latency_early got=%b exp=0", ev_valid); end
    @(negedge clk);
    checks += 3;
    if (ev_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", ev_valid); end
    if (ev_data !== 8'h82) begin failures++; $display("FAIL single_data got=%h exp=82", ev_data); end
    if (ev_count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", ev_count); end
`ifndef BTN_EVQ_TIMESTAMP_EN
    checks++;
    if (ev_ts !== 16'h0) begin failures++; $display("FAIL single_ts_off got=%h exp=0000", ev_ts); end
`endif
    @(negedge clk);
    btn_shrt[2] = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (ev_count !== 4'd1) begin failures++; $display("FAIL single_one_entry got=%0d exp=1", ev_count); end
    exp_q.push_back(8'h82);
    ev_ready = 1'b1; c = 0;
    while (exp_q.size() != 0 && c < 50) begin
      if (ev_valid) begin
        e = exp_q.pop_front(); checks++;
        if (ev_data !== e) begin failures++; $display("FAIL single_drain got=%h exp=%h", ev_data, e); end
      end
      @(negedge clk); c++;
    end
    ev_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || ev_count !== 4'd0) begin
      failures++; $display("FAIL single_empty left=%0d count=%0d exp=0", exp_q.size(), ev_count);
    end
    exp_q.delete();
  endtask

  task automatic test_simultaneous();
    logic [7:0] e;
    int c;
    btn_long[1] = 1'b1; btn_down[0] = 1'b1;
    @(negedge clk);
    clear_inputs();
    repeat (4) @(negedge clk);
    checks++;
    if (ev_count !== 4'd2) begin failures++; $display("FAIL simul_count got=%0d exp=2", ev_count); end
    exp_q.push_back(8'h00); exp_q.push_back(8'hC1);
    ev_ready = 1'b1; c = 0;
    while (exp_q.size() != 0 && c < 50) begin
      if (ev_valid) begin
        e = exp_q.pop_front(); checks++;
        if (ev_data !== e) begin failures++; $display("FAIL simul_order got=%h exp=%h", ev_data, e); end
      end
      @(negedge clk); c++;
    end
    ev_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL simul_timeout left=%0d exp=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_full();
    logic [7:0] e;
    logic [7:0] lst [10] = '{8'h00, 8'h40, 8'h80, 8'h01, 8'h41, 8'h81, 8'h02, 8'h42, 8'h03, 8'h43};
    int c;
    btn_down = 4'hF; btn_up = 4'hF; btn_shrt = 4'h3;
    repeat (20) @(negedge clk);
    checks += 2;
    if (ev_count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", ev_count); end
    if (ovf !== 1'b0)      begin failures++; $display("FAIL full_ovf got=%b exp=0", ovf); end
    clear_inputs();
    @(negedge clk);
    foreach (lst[i]) exp_q.push_back(lst[i]);
    ev_ready = 1'b1; c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      if (ev_valid) begin
        e = exp_q.pop_front(); checks++;
        if (ev_data !== e) begin failures++; $display("FAIL full_order got=%h exp=%h", ev_data, e); end
      end
      @(negedge clk); c++;
    end
    ev_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks += 2;
    if (exp_q.size() != 0 || ev_count !== 4'd0) begin
      failures++; $display("FAIL full_drain left=%0d count=%0d exp=0", exp_q.size(), ev_count);
    end
    if (ovf !== 1'b0) begin failures++; $display("FAIL full_ovf_after got=%b exp=0", ovf); end
    exp_q.delete();
  endtask

  task automatic test_merge();
    logic [7:0] e;
    logic [7:0] lst [9] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h01, 8'h41, 8'h81, 8'hC1, 8'h43};
    int c;
    btn_down = 4'h3; btn_up = 4'h3; btn_shrt = 4'h3; btn_long = 4'h3;
    repeat (15) @(negedge clk);
    clear_inputs();
    @(negedge clk);
    btn_up[3] = 1'b1; @(negedge clk);
    btn_up[3] = 1'b0; @(negedge clk);
    checks++;
    if (ovf !== 1'b0) begin failures++; $display("FAIL merge_first_rise got=%b exp=0", ovf); end
    btn_up[3] = 1'b1; @(negedge clk);
    btn_up[3] = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin failures++; $display("FAIL merge_ovf got=%b exp=1", ovf); end
    foreach (lst[i]) exp_q.push_back(lst[i]);
    ev_ready = 1'b1; c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      if (ev_valid) begin
        e = exp_q.pop_front(); checks++;
        if (ev_data !== e) begin failures++; $display("FAIL merge_order got=%h exp=%h", ev_data, e); end
      end
      @(negedge clk); c++;
    end
    ev_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (exp_q.size() != 0 || ev_count !== 4'd0) begin
      failures++; $display("FAIL merge_single_delivery left=%0d count=%0d exp=0", exp_q.size(), ev_count);
    end
    if (ovf !== 1'b1) begin failures++; $display("FAIL merge_sticky got=%b exp=1", ovf); end
    ovf_clr = 1'b1; @(negedge clk);
    ovf_clr = 1'b0;
    if (ovf !== 1'b0) begin failures++; $display("FAIL merge_clear got=%b exp=0", ovf); end
    exp_q.delete();
  endtask

  task automatic test_full_pushpop();
    logic [7:0] e;
    logic [7:0] lst [9] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h01, 8'h41, 8'h81, 8'hC1, 8'h02};
    int c;
    btn_down = 4'h3; btn_up = 4'h3; btn_shrt = 4'h3; btn_long = 4'h3;
    repeat (15) @(negedge clk);
    clear_inputs();
    btn_down[2] = 1'b1; @(negedge clk);
    btn_down[2] = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ev_count !== 4'd8) begin failures++; $display("FAIL pp_full got=%0d exp=8", ev_count); end
    foreach (lst[i]) exp_q.push_back(lst[i]);
    ev_ready = 1'b1;
    e = exp_q.pop_front(); checks++;
    if (ev_data !== e) begin failures++; $display("FAIL pp_head got=%h exp=%h", ev_data, e); end
    @(negedge clk);
    ev_ready = 1'b0;
    checks++;
    if (ev_count !== 4'd8) begin failures++; $display("FAIL pp_count_held got=%0d exp=8", ev_count); end
    ev_ready = 1'b1; c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      if (ev_valid) begin
        e = exp_q.pop_front(); checks++;
        if (ev_data !== e) begin failures++; $display("FAIL pp_order got=%h exp=%h", ev_data, e); end
      end
      @(negedge clk); c++;
    end
    ev_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0 || ev_count !== 4'd0) begin
      failures++; $display("FAIL pp_drain left=%0d count=%0d exp=0", exp_q.size(), ev_count);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    int max_cnt = 0;
    ev_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) begin
        btn_down[c] = 1'b1;
        exp_q.push_back(8'(c));
      end
      if (ev_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front(); checks++;
        if (ev_data !== e) begin failures++; $display("FAIL b2b_order got=%h exp=%h", ev_data, e); end
      end
      if (int'(ev_count) > max_cnt) max_cnt = int'(ev_count);
      @(negedge clk);
    end
    ev_ready = 1'b0;
    clear_inputs();
    checks += 2;
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_delivered left=%0d exp=0", exp_q.size()); end
    if (max_cnt > 1) begin failures++; $display("FAIL b2b_throughput max_count=%0d exp<=1", max_cnt); end
    @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    btn_down = 4'hF; btn_up = 4'hF; btn_shrt = 4'h3;
    repeat (20) @(negedge clk);
    checks++;
    if (ev_count !== 4'd8) begin failures++; $display("FAIL rmid_full got=%0d exp=8", ev_count); end
    clear_inputs();
    rstn = 1'b0;
    @(negedge clk);
    checks += 2;
    if (ev_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", ev_valid); end
    if (ev_count !== 4'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", ev_count); end
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (ev_count !== 4'd0) begin failures++; $display("FAIL rmid_pending_cleared got=%0d exp=0", ev_count); end
  endtask

`ifdef BTN_EVQ_TIMESTAMP_EN
  task automatic test_timestamp();
    rstn = 1'b0; clear_inputs(); ev_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    btn_down[0] = 1'b1; @(negedge clk);
    btn_down[0] = 1'b0;
    repeat (69999) @(negedge clk);
    btn_down[1] = 1'b1; @(negedge clk);
    btn_down[1] = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (ev_count !== 4'd2) begin failures++; $display("FAIL ts_count got=%0d exp=2", ev_count); end
    if (ev_ts !== 16'd5)   begin failures++; $display("FAIL ts_first got=%0d exp=5", ev_ts); end
    ev_ready = 1'b1; @(negedge clk);
    ev_ready = 1'b0;
    if (ev_data !== 8'h01)   begin failures++; $display("FAIL ts_second_data got=%h exp=01", ev_data); end
    if (ev_ts !== 16'd4469)  begin failures++; $display("FAIL ts_second got=%0d exp=4469", ev_ts); end
    ev_ready = 1'b1; @(negedge clk);
    ev_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_full();
    test_merge();
    test_full_pushpop();
    test_back_to_back();
    test_reset_mid();
`ifdef BTN_EVQ_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
